// File: rtl/led_display_pkg.sv
// led_display_pkg: shared constants and hex-to-segment decode for the LED scan controller
package led_display_pkg;
  localparam int DIGITS_DEF = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] DIG_OFF = 8'hFF;
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h71, 8'h61, 8'h85, 8'hE5, 8'hC1, 8'h11, 8'h19, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction
endpackage

// File: rtl/led_scan_timer.sv
// led_scan_timer: slot counter and digit index with slot, frame and blank-phase flags
module led_scan_timer #(
  parameter int SCAN_DIV  = 20000,
  parameter int BLANK_CYC = 200,
  parameter int DIGITS    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [$clog2(DIGITS)-1:0] idx,
  output logic                      slot_tick,
  output logic                      frame_tick,
  output logic                      blank
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  logic [CW-1:0] cnt;
  assign slot_tick  = cnt == CW'(SCAN_DIV - 1);
  assign frame_tick = slot_tick && idx == IW'(DIGITS - 1);
  assign blank      = cnt < CW'(BLANK_CYC);
  // advance the slot counter every cycle and step the digit on each slot tick
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_tick ? '0 : cnt + 1'b1;
      if (slot_tick) idx <= frame_tick ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: double-buffered 8-digit seven-segment scan driver
module led_scan_ctrl
  import led_display_pkg::*;
#(
  parameter int DIGITS    = DIGITS_DEF,
  parameter int SCAN_DIV  = 20000,
  parameter int BLANK_CYC = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  output logic [DIGITS-1:0] digit_en,
  output logic [7:0]        segment_en,
  output logic              pending,
  output logic              frame_start
);
  localparam int IW = $clog2(DIGITS);
  logic [IW-1:0] idx;
  logic          slot_tick, frame_tick, blank;
  logic [31:0]   disp_q, pend_q;
  logic          pend_v;
  led_scan_timer #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .DIGITS(DIGITS)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .slot_tick  (slot_tick),
    .frame_tick (frame_tick),
    .blank      (blank)
  );
  assign pending = pend_v;
  // hold writes until the frame boundary; a write landing on the boundary bypasses the buffer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      disp_q <= '0;
      pend_q <= '0;
      pend_v <= 1'b0;
    end else if (frame_tick) begin
      disp_q <= wr_en ? wr_data : pend_v ? pend_q : disp_q;
      pend_v <= 1'b0;
    end else if (wr_en) begin
      pend_q <= wr_data;
      pend_v <= 1'b1;
    end
  // register the digit select and segment pattern for the active slot phase
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      digit_en    <= DIGITS'(DIG_OFF);
      segment_en  <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      digit_en    <= blank ? DIGITS'(DIG_OFF) : ~(DIGITS'(1) << idx);
      segment_en  <= blank ? SEG_OFF : hex_to_seg(disp_q[{idx, 2'b00} +: 4]);
      frame_start <= frame_tick;
    end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: randomized and directed checks of the scan driver against a frame-level model
module tb_led_scan_ctrl;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FRAME = 8 * SD;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [7:0]  digit_en, segment_en;
  logic        pending, frame_start;
  int n_cmp = 0;
  int n_err = 0;
  int t = 0;
  logic [31:0] m_disp = '0;
  logic [31:0] m_pend = '0;
  logic        m_pv = 1'b0;
  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h19, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71};
  led_scan_ctrl #(.DIGITS(8), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .digit_en    (digit_en),
    .segment_en  (segment_en),
    .pending     (pending),
    .frame_start (frame_start)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask
  task automatic tick();
    int c, i;
    logic bnd;
    logic [7:0] e_dig, e_seg;
    c = t % SD;
    i = (t / SD) % 8;
    bnd = (t % FRAME) == FRAME - 1;
    e_dig = (c < BC) ? 8'hFF : ~(8'h01 << i);
    e_seg = (c < BC) ? 8'hFF : seg_tab[(m_disp >> (4 * i)) & 32'hF];
    if (bnd) begin
      if (wr_en) m_disp = wr_data;
      else if (m_pv) m_disp = m_pend;
      m_pv = 1'b0;
    end else if (wr_en) begin
      m_pend = wr_data;
      m_pv = 1'b1;
    end
    t++;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("digit_en", {24'b0, digit_en}, {24'b0, e_dig});
    check("segment_en", {24'b0, segment_en}, {24'b0, e_seg});
    check("pending", {31'b0, pending}, {31'b0, m_pv});
    check("frame_start", {31'b0, frame_start}, {31'b0, bnd});
    check("one_digit", $countones(~digit_en) <= 1, 1);
    check("dp_off", {31'b0, segment_en[0]}, 1);
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic run_to(input int phase);
    while ((t % FRAME) != phase) tick();
  endtask
  task automatic write(input logic [31:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_dig", {24'b0, digit_en}, 32'hFF);
    check("rst_seg", {24'b0, segment_en}, 32'hFF);
    check("rst_pend", {31'b0, pending}, 0);
    check("rst_fs", {31'b0, frame_start}, 0);
    m_disp = '0;
    m_pv = 1'b0;
    t = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    run(2 * FRAME + 5);
    run_to(10);
    write(32'h76543210);
    run(2 * FRAME);
    run_to(5);
    write(32'h11111111);
    run_to(12);
    write(32'hFEDCBA98);
    run(2 * FRAME);
    run_to(3);
    write(32'hAAAAAAAA);
    run_to(FRAME - 1);
    write(32'h55555555);
    run(FRAME + 4);
    run_to(16);
    write(32'h12345678);
    run_to(21);
    do_reset();
    run(2 * FRAME);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      wr_en = ($urandom_range(0, 19) == 0);
      wr_data = $urandom;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Time-multiplexed driver for the 8-digit seven-segment display peripheral of the miniRV SoC. It holds a 32-bit value written by the bus-side peripheral logic and scans the digits one at a time. For the active digit it drives an active-low digit-select line and the active-low segment pattern for that digit's hex nibble. New data is double-buffered and takes effect only at a frame boundary, so the display never tears.

## Interface
Parameters:
- DIGITS, 8: number of digits scanned; fixed at 8 for this SoC.
- SCAN_DIV, 20000: clk cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 200: leading cycles of each slot with all digits off (anti-ghosting); must be < SCAN_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (low = reset).
- wr_en  in  1  one-cycle write strobe from the peripheral address decode.
- wr_data  in  32  display value; nibble i (bits 4i+3:4i) shows on digit i.
- digit_en  out  8  active-low digit select; at most one bit low at any time.
- segment_en  out  8  active-low segments, bit7..bit0 = a,b,c,d,e,f,g,dp; dp is always off (1).
- pending  out  1  high while a written value waits for the next frame boundary.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Internal state: cnt (0..SCAN_DIV-1), idx (0..DIGITS-1), disp_q[31:0] (shown value), pend_q[31:0], pend_v.
- Every cycle cnt increments. At cnt == SCAN_DIV-1 (the slot tick), cnt goes to 0 and idx increments. idx wraps from DIGITS-1 to 0.
- Frame boundary is a slot tick with idx == DIGITS-1.
- A write with wr_en=1 and no boundary this cycle sets pend_q to wr_data and pend_v to 1. A later write before the boundary overwrites pend_q (last write wins).
- At a boundary:
  - If wr_en=1 in the same cycle, disp_q takes wr_data directly (bypass) and pend_v clears.
  - Otherwise, if pend_v=1, disp_q takes pend_q and pend_v clears.
  - Otherwise disp_q holds.
- Decode maps nibble to pattern (a..g, dp): 0→03, 1→9F, 2→25, 3→0D, 4→99, 5→49, 6→41, 7→1F, 8→01, 9→19, A→11, b→C1, C→E5, d→85, E→61, F→71 (hex values of segment_en).
- Slot phases:
  - Blank: cnt < BLANK_CYC. digit_en = FF and segment_en = FF.
  - Drive: otherwise. digit_en has only bit idx low, and segment_en = decode(disp_q nibble idx).
- Reset mid-scan clears everything immediately, including any pending write, which is lost.

## Timing
- Reset values: digit_en=FF, segment_en=FF, pending=0, frame_start=0. Internally cnt=0, idx=0, disp_q=0, pend_v=0.
- All outputs are registered, so each output reflects the cycle-t state at t+1.
- frame_start is high in the cycle after the boundary tick, i.e. the first cycle of digit 0's blank phase.
- pending goes to 1 the cycle after a non-boundary write, and to 0 the cycle after the boundary.
- After reset release, digit 0 is first driven BLANK_CYC+1 cycles later.
- Frame period is DIGITS×SCAN_DIV cycles. The worst-case write-to-display delay is one frame plus BLANK_CYC+1 cycles.
- A digit switch always passes through the blank phase, so no cycle has two digits low.

## Structure
- Package led_display_pkg holds:
  - SEG_OFF = 8'hFF and DIG_OFF = 8'hFF.
  - The 16-entry pattern constants plus a function hex_to_seg(nibble).
  - The default DIGITS.
- Sub-module led_scan_timer contains cnt and idx. It outputs idx, slot_tick, frame_tick and blank. Parameters are SCAN_DIV, BLANK_CYC and DIGITS.
- The top level contains the double buffer, decode and output registers.

## Test plan
All scenarios use SCAN_DIV=4, BLANK_CYC=1.
- Reset and scan: hold rst low, then release with no writes. All outputs read FF during reset. From cycle 2, digit_en steps through FE,FD,…,7F with segment_en=03 in drive cycles and FF in blank cycles. frame_start pulses every 32 cycles.
- Single write: wr_data=32'h76543210 mid-frame. pending rises, the current frame still shows all zeros, and the next frame shows digit i with the pattern for i (digit 2 → 25).
- Overwrite: write 32'h11111111 then 32'hFEDCBA98 in the same frame. Only FEDCBA98 appears, digit 0 → 01 and digit 7 → 71.
- Boundary collision: pend holds 32'hAAAAAAAA and wr_en with 32'h55555555 lands on the boundary tick. The next frame shows all 49 and pending=0.
- Reset mid-operation: assert rst during digit 5 with pend_v=1. Outputs go to FF asynchronously. After release, the display shows zeros and pending=0.
- Invariant checker, run across all scenarios: popcount(~digit_en) ≤ 1 every cycle, and segment_en bit0 = 1 always.
